// File: rtl/board_generator.sv
// Minesweeper board builder: seeds an LFSR, scatters bombs while sparing the first-click cell,
// then writes each cell's adjacent-bomb count in a 64-cycle row-major scan.
module board_generator (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [15:0]           seed,
  input  logic [5:0]            num_bombs,
  input  logic [3:0]            safe_x,
  input  logic [3:0]            safe_y,
  output logic [7:0][7:0][8:0]  matrix,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {IDLE, CLEAR, PLACE, COUNT, DONE} state_t;

  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  state_t       state;
  state_t       state_next;
  logic [15:0]  lfsr;
  logic [15:0]  lfsr_step;
  logic [5:0]   target;
  logic [5:0]   placed;
  logic [5:0]   idx;
  logic [3:0]   safe_col;
  logic [3:0]   safe_row;
  logic [2:0]   cand_row;
  logic [2:0]   cand_col;
  logic         cand_ok;
  logic [2:0]   scan_row;
  logic [2:0]   scan_col;
  logic [3:0]   adj_count;
  logic signed [4:0] nr;
  logic signed [4:0] nc;

  assign lfsr_step = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign cand_row  = lfsr[5:3];
  assign cand_col  = lfsr[2:0];
  assign cand_ok   = !({1'b0, cand_row} == safe_row && {1'b0, cand_col} == safe_col)
                     && !matrix[cand_row][cand_col][0];
  assign scan_row  = idx[5:3];
  assign scan_col  = idx[2:0];

  // Neighbour bombs around the scanned cell; off-board positions are simply skipped.
  always_comb begin
    adj_count = '0;
    nr        = '0;
    nc        = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        nr = $signed({2'b00, scan_row}) + 5'(dr);
        nc = $signed({2'b00, scan_col}) + 5'(dc);
        if (!(dr == 0 && dc == 0) && nr >= 5'sd0 && nr <= 5'sd7
            && nc >= 5'sd0 && nc <= 5'sd7) begin
          adj_count = adj_count + {3'b000, matrix[nr[2:0]][nc[2:0]][0]};
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CLEAR;
      CLEAR:   state_next = PLACE;
      PLACE:   if (placed == target) state_next = COUNT;
      COUNT:   if (idx == 6'd63) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      matrix   <= '0;
      lfsr     <= DEFAULT_SEED;
      target   <= '0;
      placed   <= '0;
      idx      <= '0;
      safe_col <= '0;
      safe_row <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            lfsr     <= (seed == 16'd0) ? DEFAULT_SEED : seed;
            target   <= (num_bombs == 6'd0) ? 6'd1 :
                        (num_bombs > 6'd32) ? 6'd32 : num_bombs;
            // Only the low three bits address the 8x8 board.
            safe_col <= safe_x & 4'b0111;
            safe_row <= safe_y & 4'b0111;
          end
        end
        CLEAR: begin
          matrix <= '0;
          placed <= '0;
          idx    <= '0;
        end
        PLACE: begin
          lfsr <= lfsr_step;
          if (placed != target && cand_ok) begin
            matrix[cand_row][cand_col][0] <= 1'b1;
            placed <= placed + 6'd1;
          end
        end
        COUNT: begin
          matrix[scan_row][scan_col][4:1] <= adj_count;
          idx <= idx + 6'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == CLEAR) || (state == PLACE) || (state == COUNT);
  assign done = (state == DONE);

endmodule
